// File: rtl/uart_encoder_if.sv
// Card-value bundle shared between the game logic and the UART framing stage.
// Ports: card_values[0:8] - nine 4-bit card values.
// Modport 'in' is the consumer view used by uart_encoder.
interface UART_if;
  logic [3:0] card_values [0:8];

  modport in (input card_values);
endinterface

// File: rtl/uart_encoder.sv
// Transmit framing for the inter-board game link: turns changed flag/card fields into UART bytes.
// Latency: input change sampled at edge N gives wr_uart in the cycle after N; writes spaced GAP_CYCLES+1 (min 2).
// Backpressure: tx_full is sampled only in IDLE; while it is high nothing is written and changes stay pending.
//
// Ports:
//   clk, rst (async, active-low)     clock and reset
//   deal, dealer_finished, start     local game flags (frame 0)
//   encoder_cards                    nine card values (frames 1..9)
//   tx_full                          UART TX FIFO full
//   wr_uart, write_data              one-cycle write strobe and byte {field, index}
//   busy                             frames pending or FSM not idle, as of the previous edge
module uart_encoder #(
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned REFRESH_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       deal,
  input  logic       dealer_finished,
  input  logic       start,
  UART_if.in         encoder_cards,
  input  logic       tx_full,
  output logic       wr_uart,
  output logic [7:0] write_data,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t      state;
  logic [3:0]  field  [0:9];   // current 4-bit payload of each frame
  logic [3:0]  shadow [0:9];   // payload last transmitted for each frame
  logic [9:0]  force_bits;
  logic [9:0]  dirty;
  logic [9:0]  pending;
  logic [9:0]  sel_oh;
  logic [3:0]  sel_idx;
  logic [3:0]  sel_field;
  logic [31:0] gap_cnt;
  logic [31:0] refresh_cnt;
  logic        refresh_wrap;

  // Frame 0 packs the flags so that {field, index} yields {0, start, deal, dealer_finished, 4'h0}.
  always_comb begin
    field[0] = {1'b0, start, deal, dealer_finished};
    for (int i = 1; i < 10; i++) begin
      field[i] = encoder_cards.card_values[i-1];
    end
  end

  always_comb begin
    dirty = '0;
    for (int i = 0; i < 10; i++) begin
      dirty[i] = (field[i] != shadow[i]);
    end
  end

  assign pending = dirty | force_bits;

  // Lowest pending index wins: scan downwards so the last hit is the lowest.
  always_comb begin
    sel_oh    = '0;
    sel_idx   = '0;
    sel_field = '0;
    for (int i = 9; i >= 0; i--) begin
      if (pending[i]) begin
        sel_oh    = 10'b1 << i;
        sel_idx   = 4'(i);
        sel_field = field[i];
      end
    end
  end

  assign refresh_wrap = (REFRESH_CYCLES != 0) && (refresh_cnt == REFRESH_CYCLES - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wr_uart     <= 1'b0;
      write_data  <= 8'h00;
      busy        <= 1'b0;
      gap_cnt     <= '0;
      refresh_cnt <= '0;
      force_bits  <= '1;       // full resync burst after every reset
      for (int i = 0; i < 10; i++) begin
        shadow[i] <= 4'h0;
      end
    end else begin
      busy <= (state != IDLE) || (pending != '0);

      if (REFRESH_CYCLES != 0) begin
        refresh_cnt <= refresh_wrap ? 32'd0 : refresh_cnt + 32'd1;
      end

      case (state)
        IDLE: begin
          if ((pending != '0) && !tx_full) begin
            write_data <= {sel_field, sel_idx};
            wr_uart    <= 1'b1;
            for (int i = 0; i < 10; i++) begin
              if (sel_oh[i]) shadow[i] <= field[i];
            end
            force_bits <= force_bits & ~sel_oh;
            state      <= SEND;
          end
        end
        SEND: begin
          wr_uart <= 1'b0;
          // The IDLE decision cycle is itself the last gap cycle, so GAP
          // only covers GAP_CYCLES-1 cycles; 0 and 1 both skip it.
          if (GAP_CYCLES < 2) begin
            state <= IDLE;
          end else begin
            gap_cnt <= GAP_CYCLES - 1;
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt <= 32'd1) begin
            gap_cnt <= '0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 32'd1;
          end
        end
        default: begin
          wr_uart <= 1'b0;
          state   <= IDLE;
        end
      endcase

      // Placed after the send so a coinciding wrap overrides the force-bit clear.
      if (refresh_wrap) force_bits <= '1;
    end
  end

endmodule

// File: tb/tb_uart_encoder.sv
module tb_uart_encoder;

  logic       clk;
  logic       rst, rst_r;
  logic       deal, dealer_finished, start, tx_full;
  logic       wr_uart, busy;
  logic [7:0] write_data;
  logic       wr_r, busy_r;
  logic [7:0] wd_r;

  UART_if cards_if();
  UART_if cards_r();

  uart_encoder #(.GAP_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .deal(deal), .dealer_finished(dealer_finished),
    .start(start), .encoder_cards(cards_if), .tx_full(tx_full),
    .wr_uart(wr_uart), .write_data(write_data), .busy(busy)
  );

  uart_encoder #(.GAP_CYCLES(2), .REFRESH_CYCLES(100)) dut_r (
    .clk(clk), .rst(rst_r), .deal(1'b0), .dealer_finished(1'b0),
    .start(1'b0), .encoder_cards(cards_r), .tx_full(1'b0),
    .wr_uart(wr_r), .write_data(wd_r), .busy(busy_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_checks = 0;

  // Refresh DUT write log, cycles relative to its reset release.
  bit         rec_en = 0;
  int         rel_r = 0;
  int         rq_cyc[$];
  logic [7:0] rq_dat[$];

  always @(negedge clk) begin
    if (rec_en && wr_r && (cyc - rel_r) < 360) begin
      rq_cyc.push_back(cyc - rel_r);
      rq_dat.push_back(wd_r);
    end
  end

  typedef struct {
    logic [2:0] flags;   // {start, deal, dealer_finished}
    int         idx;
    logic [3:0] val;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_write(input int max_cyc, output bit got, output logic [7:0] data,
                            output int waited);
    waited = 0;
    got    = 0;
    data   = 8'h00;
    while (waited < max_cyc && !got) begin
      step();
      waited++;
      if (wr_uart) begin
        got  = 1;
        data = write_data;
      end
    end
  endtask

  task automatic no_write(input int n, input string name);
    bit seen = 0;
    repeat (n) begin
      step();
      if (wr_uart) seen = 1;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  function automatic logic [7:0] exp_byte(input int i);
    logic [3:0] idx;
    idx = i[3:0];
    if (i == 0) return {1'b0, start, deal, dealer_finished, 4'h0};
    return {cards_if.card_values[i-1], idx};
  endfunction

  // Expects frames 0..9 built from current inputs, first one cycle after a release.
  task automatic expect_burst(input string name);
    bit got; logic [7:0] d; int w;
    for (int j = 0; j < 10; j++) begin
      wait_write(10, got, d, w);
      check({name, "_got"}, 32'(got), 32'd1);
      check({name, "_data"}, 32'(d), 32'(exp_byte(j)));
      check({name, "_spacing"}, 32'(w), (j == 0) ? 32'd1 : 32'd3);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit got; logic [7:0] d; int w; bit seen;

    vecs[0] = '{3'b000, 4, 4'hA, 8'hA5};
    vecs[1] = '{3'b001, 4, 4'hA, 8'h10};
    vecs[2] = '{3'b011, 4, 4'hA, 8'h30};
    vecs[3] = '{3'b011, 8, 4'hF, 8'hF9};
    vecs[4] = '{3'b111, 8, 4'hF, 8'h70};
    vecs[5] = '{3'b111, 0, 4'h7, 8'h71};
    vecs[6] = '{3'b000, 0, 4'h7, 8'h00};
    vecs[7] = '{3'b000, 4, 4'h0, 8'h05};

    rst = 1'b0; rst_r = 1'b0;
    deal = 1'b0; dealer_finished = 1'b0; start = 1'b0; tx_full = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cards_if.card_values[i] = 4'h0;
      cards_r.card_values[i]  = 4'h0;
    end
    step(); step();

    check("reset_wr_uart", 32'(wr_uart), 32'd0);
    check("reset_write_data", 32'(write_data), 32'h00);
    check("reset_busy", 32'(busy), 32'd0);

    // Release: full resync burst 0x00..0x09, 3 cycles apart.
    rst = 1'b1; rst_r = 1'b1; rel_r = cyc; rec_en = 1;
    expect_burst("init_burst");
    check("burst_busy", 32'(busy), 32'd1);
    no_write(20, "init_quiet");
    check("idle_busy", 32'(busy), 32'd0);

    // Single-field changes, each sent one cycle after the sampling edge.
    for (int v = 0; v < 8; v++) begin
      {start, deal, dealer_finished} = vecs[v].flags;
      cards_if.card_values[vecs[v].idx] = vecs[v].val;
      step();
      check($sformatf("vec%0d_wr", v), 32'(wr_uart), 32'd1);
      check($sformatf("vec%0d_data", v), 32'(write_data), 32'(vecs[v].exp));
      no_write(6, $sformatf("vec%0d_single", v));
      check($sformatf("vec%0d_hold", v), 32'(write_data), 32'(vecs[v].exp));
    end

    // Two fields change together: flags frame first, then card 0.
    deal = 1'b1; start = 1'b1; cards_if.card_values[0] = 4'h3;
    wait_write(5, got, d, w);
    check("multi_first_got", 32'(got), 32'd1);
    check("multi_first_data", 32'(d), 32'h60);
    check("multi_first_latency", 32'(w), 32'd1);
    wait_write(10, got, d, w);
    check("multi_second_got", 32'(got), 32'd1);
    check("multi_second_data", 32'(d), 32'h31);
    check("multi_second_spacing", 32'(w), 32'd3);
    no_write(8, "multi_quiet");

    // tx_full holds off writes; card 3 bounces back before it can be selected.
    tx_full = 1'b1;
    cards_if.card_values[2] = 4'h5;
    cards_if.card_values[3] = 4'h9;
    seen = 0;
    repeat (3) begin step(); if (wr_uart) seen = 1; end
    cards_if.card_values[3] = 4'h0;
    repeat (5) begin step(); if (wr_uart) seen = 1; end
    check("txfull_blocked", 32'(seen), 32'd0);
    tx_full = 1'b0;
    step();
    check("txfull_release_wr", 32'(wr_uart), 32'd1);
    check("txfull_release_data", 32'(write_data), 32'h53);
    // Card 2 changes again right after being sent: re-sent after the gap.
    cards_if.card_values[2] = 4'h6;
    wait_write(10, got, d, w);
    check("resend_got", 32'(got), 32'd1);
    check("resend_data", 32'(d), 32'h63);
    check("resend_spacing", 32'(w), 32'd3);
    no_write(10, "bounce_not_sent");

    // Reset mid-burst: abort after the 4th byte, restart from frame 0.
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int j = 0; j < 4; j++) begin
      wait_write(10, got, d, w);
      check("pre_abort_got", 32'(got), 32'd1);
      check("pre_abort_data", 32'(d), 32'(exp_byte(j)));
    end
    rst = 1'b0;
    #1;
    check("abort_async_wr", 32'(wr_uart), 32'd0);
    check("abort_async_data", 32'(write_data), 32'h00);
    step(); step();
    rst = 1'b1;
    expect_burst("restart_burst");
    no_write(10, "restart_quiet");
    check("restart_idle_busy", 32'(busy), 32'd0);

    // Refresh DUT: bursts every 100 cycles with static all-zero inputs.
    while (cyc < rel_r + 365) step();
    check("refresh_count", 32'(rq_cyc.size()), 32'd40);
    for (int j = 0; j < 40 && j < rq_cyc.size(); j++) begin
      check($sformatf("refresh%0d_cycle", j), 32'(rq_cyc[j]),
            32'(1 + (j / 10) * 100 + (j % 10) * 3));
      check($sformatf("refresh%0d_data", j), 32'(rq_dat[j]), 32'(j % 10));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
